// File: rtl/leb128_pkg.sv
// leb128_pkg: shared constants for the LEB128 immediate fetch stage.
//   Kind codes (2 bits): U32, S32, S64; code 3 is reserved.
//   Error codes (3 bits): the value the cpu maps onto a trap code.
//   FSM state type and a helper giving the last legal byte index per kind.
package leb128_pkg;

    localparam logic [1:0] LEB_U32  = 2'd0;
    localparam logic [1:0] LEB_S32  = 2'd1;
    localparam logic [1:0] LEB_S64  = 2'd2;
    localparam logic [1:0] LEB_RSVD = 2'd3;

    localparam logic [2:0] LEB_ERR_NONE        = 3'd0;
    localparam logic [2:0] LEB_ERR_TOO_LONG    = 3'd1;
    localparam logic [2:0] LEB_ERR_BAD_PADDING = 3'd2;
    localparam logic [2:0] LEB_ERR_MEM_ERROR   = 3'd3;
    localparam logic [2:0] LEB_ERR_BAD_KIND    = 3'd4;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDone
    } leb_state_e;

    // Index of the final permitted byte: 5 bytes for 32-bit kinds, 10 for 64-bit.
    function automatic logic [3:0] leb_last_index(input logic [1:0] kind);
        return (kind == LEB_S64) ? 4'd9 : 4'd4;
    endfunction

endpackage

// File: rtl/leb128_pad_check.sv
// leb128_pad_check: combinational classifier for one encoded byte.
//   kind_i     : immediate kind (U32/S32/S64)
//   byte_i     : encoded byte (bit 7 = continuation)
//   index_i    : position of this byte within the immediate (0-based)
//   is_last_o  : this byte ends the immediate (normal stop or length limit)
//   too_long_o : continuation set on the final permitted byte
//   bad_pad_o  : final permitted byte carries bits that do not fit the kind
module leb128_pad_check
    import leb128_pkg::*;
(
    input  logic [1:0] kind_i,
    input  logic [7:0] byte_i,
    input  logic [3:0] index_i,
    output logic       is_last_o,
    output logic       too_long_o,
    output logic       bad_pad_o
);

    logic at_limit;
    logic pad_ok;

    always_comb begin
        at_limit = (index_i == leb_last_index(kind_i));
        pad_ok   = 1'b1;
        unique case (kind_i)
            LEB_U32: pad_ok = (byte_i[6:4] == 3'b000);
            LEB_S32: pad_ok = (byte_i[6:4] == {3{byte_i[3]}});
            LEB_S64: pad_ok = (byte_i[6:1] == {6{byte_i[0]}});
            default: pad_ok = 1'b1;
        endcase
        is_last_o  = !byte_i[7] || at_limit;
        too_long_o = at_limit && byte_i[7];
        // A too-long byte is reported as such, never also as bad padding.
        bad_pad_o  = at_limit && !byte_i[7] && !pad_ok;
    end

endmodule

// File: rtl/leb128_fetch.sv
// leb128_fetch: streams bytes from genrom starting at pc and decodes one
// LEB128 immediate (varuint32, varint32, varint64).
//   clk, reset          : clock, asynchronous active-high reset
//   start, kind, pc     : request (sampled in idle), immediate kind, first byte address
//   busy, done          : in progress; one-cycle result-valid pulse
//   value, length       : decoded 64-bit value, bytes consumed
//   next_pc, error      : pc + length (wrapping), error code (0 = none)
//   mem_addr, mem_extra : registered ROM byte address, always-zero extra select
//   mem_data, mem_error : ROM data (only [7:0] used) and bounds error, one-cycle latency
module leb128_fetch
    import leb128_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 6,
    parameter int unsigned MEM_EXTRA = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    kind,
    input  logic [MEM_DEPTH:0]            pc,
    output logic                          busy,
    output logic                          done,
    output logic [63:0]                   value,
    output logic [3:0]                    length,
    output logic [MEM_DEPTH:0]            next_pc,
    output logic [2:0]                    error,
    output logic [MEM_DEPTH:0]            mem_addr,
    output logic [MEM_EXTRA-1:0]          mem_extra,
    input  logic [(2**MEM_EXTRA)*8-1:0]   mem_data,
    input  logic                          mem_error
);

    localparam int unsigned AW = MEM_DEPTH + 1;

    leb_state_e state_q, state_d;

    logic [1:0]    kind_q, kind_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [3:0]    idx_q, idx_d;
    // Set once the first ROM read has returned; the cycle after start has no data.
    logic          primed_q, primed_d;
    logic [63:0]   acc_q, acc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [63:0]   value_q, value_d;
    logic [3:0]    length_q, length_d;
    logic [AW-1:0] next_pc_q, next_pc_d;
    logic [2:0]    error_q, error_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;

    logic          is_last, too_long, bad_pad;
    logic [6:0]    shamt, fill_sh;
    logic [63:0]   payload, acc_next, fill_mask;
    logic [3:0]    len_cur;
    logic          sign_fill, stop;
    logic          unused_mem_data;

    assign unused_mem_data = ^mem_data[(2**MEM_EXTRA)*8-1:8];

    leb128_pad_check u_pad_check (
        .kind_i     (kind_q),
        .byte_i     (mem_data[7:0]),
        .index_i    (idx_q),
        .is_last_o  (is_last),
        .too_long_o (too_long),
        .bad_pad_o  (bad_pad)
    );

    assign shamt     = 7'(idx_q) * 7'd7;
    assign fill_sh   = shamt + 7'd7;
    assign payload   = {57'd0, mem_data[6:0]} << shamt;
    assign acc_next  = acc_q | payload;
    // Sign fill covers bits above 7*N; a full 10-byte value needs none.
    assign fill_mask = (fill_sh >= 7'd64) ? 64'd0 : (~64'd0 << fill_sh);
    assign sign_fill = (kind_q != LEB_U32) && mem_data[6];
    assign len_cur   = idx_q + 4'd1;
    assign stop      = primed_q && (mem_error || is_last);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (kind == LEB_RSVD) ? StDone : StStream;
                end
            end
            StStream: begin
                if (stop) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        kind_d     = kind_q;
        pc_d       = pc_q;
        idx_d      = idx_q;
        primed_d   = primed_q;
        acc_d      = acc_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        value_d    = value_q;
        length_d   = length_q;
        next_pc_d  = next_pc_q;
        error_d    = error_q;
        mem_addr_d = mem_addr_q;
        unique case (state_q)
            StIdle: begin
                if (start && (kind == LEB_RSVD)) begin
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    value_d   = 64'd0;
                    length_d  = 4'd0;
                    next_pc_d = pc;
                    error_d   = LEB_ERR_BAD_KIND;
                end else if (start) begin
                    kind_d     = kind;
                    pc_d       = pc;
                    mem_addr_d = pc;
                    busy_d     = 1'b1;
                    idx_d      = 4'd0;
                    primed_d   = 1'b0;
                    acc_d      = 64'd0;
                end
            end
            StStream: begin
                mem_addr_d = mem_addr_q + 1'b1;
                primed_d   = 1'b1;
                if (primed_q) begin
                    acc_d = acc_next;
                    idx_d = len_cur;
                end
                if (stop) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    length_d  = len_cur;
                    next_pc_d = pc_q + AW'(len_cur);
                    if (mem_error) begin
                        error_d = LEB_ERR_MEM_ERROR;
                    end else if (too_long) begin
                        error_d = LEB_ERR_TOO_LONG;
                    end else if (bad_pad) begin
                        error_d = LEB_ERR_BAD_PADDING;
                    end else begin
                        error_d = LEB_ERR_NONE;
                    end
                    if (mem_error || too_long || bad_pad) begin
                        value_d = 64'd0;
                    end else if (sign_fill) begin
                        value_d = acc_next | fill_mask;
                    end else begin
                        value_d = acc_next;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kind_q     <= LEB_U32;
            pc_q       <= '0;
            idx_q      <= 4'd0;
            primed_q   <= 1'b0;
            acc_q      <= 64'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            value_q    <= 64'd0;
            length_q   <= 4'd0;
            next_pc_q  <= '0;
            error_q    <= LEB_ERR_NONE;
            mem_addr_q <= '0;
        end else begin
            kind_q     <= kind_d;
            pc_q       <= pc_d;
            idx_q      <= idx_d;
            primed_q   <= primed_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            value_q    <= value_d;
            length_q   <= length_d;
            next_pc_q  <= next_pc_d;
            error_q    <= error_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign value     = value_q;
    assign length    = length_q;
    assign next_pc   = next_pc_q;
    assign error     = error_q;
    assign mem_addr  = mem_addr_q;
    assign mem_extra = '0;

endmodule

// File: tb/tb_leb128_fetch.sv
// tb_leb128_fetch: self-checking bench for leb128_fetch with a behavioural ROM
// (one-cycle latency, configurable upper bound) and an arithmetic LEB128 model.
module tb_leb128_fetch;

    localparam int DEPTH = 6;
    localparam int EXTRA = 4;
    localparam int NADDR = 128;
    localparam int DW    = (2**EXTRA)*8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            start = 1'b0;
    logic [1:0]      kind = 2'd0;
    logic [DEPTH:0]  pc = '0;
    logic            busy, done;
    logic [63:0]     value;
    logic [3:0]      length;
    logic [DEPTH:0]  next_pc;
    logic [2:0]      error;
    logic [DEPTH:0]  mem_addr;
    logic [EXTRA-1:0] mem_extra;
    logic [DW-1:0]   mem_data = '0;
    logic            mem_error = 1'b0;

    logic [7:0] rom [NADDR];
    int         bound = NADDR;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data  <= {120'hA5A5_5A5A_C3C3_3C3C_F0F0_0F0F_9696, rom[mem_addr]};
        mem_error <= (int'(mem_addr) >= bound);
    end

    leb128_fetch #(
        .MEM_DEPTH (DEPTH),
        .MEM_EXTRA (EXTRA)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .kind      (kind),
        .pc        (pc),
        .busy      (busy),
        .done      (done),
        .value     (value),
        .length    (length),
        .next_pc   (next_pc),
        .error     (error),
        .mem_addr  (mem_addr),
        .mem_extra (mem_extra),
        .mem_data  (mem_data),
        .mem_error (mem_error)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Writes n bytes (byte 0 in the low octet) starting at p, wrapping.
    task automatic load(input int p, input logic [79:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            rom[(p + i) % NADDR] = bytes[8*i +: 8];
        end
    endtask

    // Reference decode: arithmetic LEB128 with two's-complement sign handling.
    task automatic ref_decode(input int k, input int p, output logic [63:0] v,
                              output int len, output int err);
        int lim;
        logic [7:0] b;
        v   = 64'd0;
        len = 0;
        err = 0;
        if (k == 3) begin
            err = 4;
            return;
        end
        lim = (k == 2) ? 10 : 5;
        for (int i = 0; i < lim; i++) begin
            int a;
            a   = (p + i) % NADDR;
            len = i + 1;
            if (a >= bound) begin
                err = 3;
                v   = 64'd0;
                return;
            end
            b = rom[a];
            v = v + (64'(b & 8'h7F) << (7 * i));
            if (i == lim - 1) begin
                if (b >= 8'd128) err = 1;
                else if (k == 0 && (b >> 4) != 8'd0) err = 2;
                else if (k == 1 && (b >> 3) != 8'd0 && (b >> 3) != 8'd15) err = 2;
                else if (k == 2 && b != 8'h00 && b != 8'h7F) err = 2;
            end
            if (err != 0) begin
                v = 64'd0;
                return;
            end
            if (b < 8'd128 || i == lim - 1) begin
                if (k != 0 && b[6] && 7 * (i + 1) < 64) begin
                    v = v - (64'd1 << (7 * (i + 1)));
                end
                return;
            end
        end
    endtask

    // Issues one request and checks latency, outputs and the single-cycle done.
    task automatic run_txn(input int k, input int p, input bit poke,
                           input logic [63:0] exp_v, input int exp_len, input int exp_err);
        int  edges;
        bit  got;
        edges = 0;
        got   = 1'b0;
        @(negedge clk);
        start = 1'b1;
        kind  = 2'(k);
        pc    = 7'(p);
        @(posedge clk);
        #1;
        start = 1'b0;
        kind  = 2'(k);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (c == 0) check_eq("busy_after_start", busy, 1);
            if (poke && c == 0) begin
                start = 1'b1;
                kind  = 2'd3;
                pc    = 7'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b0;
        check_eq("done_seen", got, 1);
        if (got) begin
            check_eq("latency", edges, (k == 3) ? 0 : exp_len + 1);
            check_eq("busy_at_done", busy, 0);
            check_eq("value", value, exp_v);
            check_eq("length", length, exp_len);
            check_eq("next_pc", next_pc, (p + exp_len) % NADDR);
            check_eq("error", error, exp_err);
            @(negedge clk);
            check_eq("done_one_cycle", done, 0);
            check_eq("value_hold", value, exp_v);
        end
    endtask

    task automatic run_ref(input int k, input int p, input bit poke);
        logic [63:0] v;
        int len, err;
        ref_decode(k, p, v, len, err);
        run_txn(k, p, poke, v, len, err);
    endtask

    initial begin
        for (int i = 0; i < NADDR; i++) rom[i] = 8'h00;
        #2 reset = 1'b1;
        #3;
        check_eq("reset_value", value, 0);
        check_eq("reset_ctrl", {busy, done, length, next_pc, error, mem_addr, mem_extra}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Directed cases with hand-computed results
        load(10, 80'h03, 1);
        run_txn(0, 10, 0, 64'd3, 1, 0);
        load(20, 80'h268EE5, 3);
        run_txn(0, 20, 0, 64'd624485, 3, 0);
        load(30, 80'h7F, 1);
        run_txn(1, 30, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        load(40, 80'h78BBC0, 3);
        run_txn(1, 40, 0, 64'hFFFF_FFFF_FFFE_1DC0, 3, 0);
        load(50, 80'h7FFFFFFFFFFFFFFFFFFF, 10);
        run_txn(2, 50, 0, 64'hFFFF_FFFF_FFFF_FFFF, 10, 0);
        load(64, 80'h7F808080808080808080, 10);
        run_txn(2, 64, 0, 64'h8000_0000_0000_0000, 10, 0);
        load(64, 80'h01808080808080808080, 10);
        run_txn(2, 64, 0, 64'd0, 10, 2);
        load(80, 80'h0FFFFFFFFF, 5);
        run_txn(0, 80, 0, 64'h0000_0000_FFFF_FFFF, 5, 0);
        load(80, 80'h1FFFFFFFFF, 5);
        run_txn(0, 80, 0, 64'd0, 5, 2);
        load(80, 80'h8080808080, 5);
        run_txn(0, 80, 0, 64'd0, 5, 1);
        run_txn(3, 5, 0, 64'd0, 0, 4);
        load(126, 80'h268EE5, 3);
        run_txn(0, 126, 0, 64'd624485, 3, 0);

        // Start while busy is ignored
        load(90, 80'h268EE5, 3);
        run_txn(0, 90, 1, 64'd624485, 3, 0);

        // ROM bound hit on the second byte
        bound = 11;
        load(10, 80'h268EE5, 3);
        run_txn(0, 10, 0, 64'd0, 2, 3);
        bound = NADDR;

        // Reset in the middle of a stream
        begin
            bit saw_done;
            saw_done = 1'b0;
            load(100, 80'h8080808080, 5);
            @(negedge clk);
            start = 1'b1;
            kind  = 2'd0;
            pc    = 7'd100;
            @(posedge clk);
            #1 start = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #2 reset = 1'b1;
            #1;
            check_eq("midreset_value", value, 0);
            check_eq("midreset_ctrl", {busy, done, length, next_pc, error, mem_addr}, 0);
            @(negedge clk);
            reset = 1'b0;
            for (int c = 0; c < 15; c++) begin
                @(negedge clk);
                if (done) saw_done = 1'b1;
            end
            check_eq("midreset_no_done", saw_done, 0);
        end

        // Randomized requests against the reference model
        for (int t = 0; t < 150; t++) begin
            int k, p, n, lidx;
            k = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            p = int'($urandom_range(0, NADDR - 1));
            n = int'($urandom_range(1, 11));
            for (int j = 0; j < 12; j++) begin
                logic [7:0] b;
                b = 8'($urandom_range(0, 127));
                if (j < n - 1) b = b | 8'h80;
                rom[(p + j) % NADDR] = b;
            end
            if ($urandom_range(0, 1) == 1) begin
                lidx = (k == 2) ? 9 : 4;
                if (k == 0) rom[(p + lidx) % NADDR] = 8'($urandom_range(0, 15));
                else if (k == 1) rom[(p + lidx) % NADDR] = ($urandom_range(0, 1) == 1) ?
                                 8'($urandom_range(120, 127)) : 8'($urandom_range(0, 7));
                else rom[(p + lidx) % NADDR] = ($urandom_range(0, 1) == 1) ? 8'h7F : 8'h00;
            end
            bound = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NADDR - 1)) : NADDR;
            run_ref(k, p, $urandom_range(0, 3) == 0 && k != 3);
        end
        bound = NADDR;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
